adder_checker: RTL

Self-checking response monitor for the 32-bit adder: the consuming end of the adder stimulus path. It captures each operand pair the stimulus side applies and queues the expected sum. It pairs each returned result, in order, with the oldest queued expectation and keeps pass/fail counts, a sticky error, and a first-failure snapshot. It sits beside the adder in the simulation top and works with combinational or pipelined adder variants.

---
 rtl/adder_checker.sv | 93 +++++++++
 1 files changed

// File: rtl/adder_checker.sv
// adder_checker: in-order scoreboard for the 32-bit adder; queues expected sums
// at push, compares returned results against the oldest one, and tracks errors.
module adder_checker #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     exp_valid,
  input  logic [WIDTH-1:0]         exp_a,
  input  logic [WIDTH-1:0]         exp_b,
  output logic                     exp_ready,
  input  logic                     res_valid,
  input  logic [WIDTH-1:0]         res_data,
  input  logic                     drain_req,
  output logic [$clog2(DEPTH):0]   pending,
  output logic [CNT_W-1:0]         pass_cnt,
  output logic [CNT_W-1:0]         fail_cnt,
  output logic                     err_sticky,
  output logic [2:0]               err_code,
  output logic [WIDTH-1:0]         first_exp,
  output logic [WIDTH-1:0]         first_got,
  output logic                     done
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count, count_nxt;
  logic [WW-1:0] wd;
  logic full, empty, push, pop, mm, uf, of, to, err;
  logic [2:0] code;
  assign full      = count == (AW+1)'(DEPTH);
  assign empty     = count == '0;
  assign exp_ready = !full;
  assign pop       = res_valid && !empty;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign push      = exp_valid && (!full || pop);
  assign mm        = pop && mem[rd_ptr] != res_data;
  assign uf        = res_valid && empty;
  assign of        = exp_valid && full && !pop;
  assign to        = !empty && !pop && wd == WW'(TIMEOUT - 1);
  assign err       = mm || uf || of || to;
  assign code      = mm ? 3'd1 : uf ? 3'd2 : of ? 3'd3 : 3'd4;
  assign count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);
  assign pending   = count;
  assign done      = state == DONE;
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     state_nxt = drain_req ? DRAIN : RUN;
      DRAIN:   state_nxt = !drain_req ? RUN : count_nxt == '0 ? DONE : DRAIN;
      DONE:    state_nxt = !drain_req ? RUN : push ? DRAIN : DONE;
      default: state_nxt = RUN;
    endcase
  end
  always_ff @(posedge CLK)
    if (push) mem[wr_ptr] <= exp_a + exp_b;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= RUN;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      wd         <= '0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      err_sticky <= 1'b0;
      err_code   <= '0;
      first_exp  <= '0;
      first_got  <= '0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      if (pop || empty) wd <= '0;
      else if (wd != WW'(TIMEOUT)) wd <= wd + 1'b1;
      if (pop && !mm && pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
      if (mm && fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
      if (err) err_sticky <= 1'b1;
      if (err && !err_sticky) err_code <= code;
      if (mm && !err_sticky) begin
        first_exp <= mem[rd_ptr];
        first_got <= res_data;
      end
    end
  end
endmodule
